reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
- Circular 32-entry reorder buffer for the Tomasulo core.
- Allocates the ROB tag that dispatch writes into the rename table.
- Captures results broadcast on the CDB and supplies ready operand values to dispatch.
- Retires instructions in program order to the architectural register file, and raises a pipeline-wide flush on a mispredicted branch or jump at the head.

Parameters:
- DEPTH, 32, number of entries; must be a power of two.
- TAG_W, 5, tag width; equals log2(DEPTH).
- XLEN, 32, data and PC width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- alloc_valid  in  1  dispatch requests an entry
- alloc_rd  in  5  destination architectural register; 0 = no writeback
- alloc_pc  in  XLEN  PC of the dispatched instruction
- alloc_ready  out  1  entry available this cycle
- alloc_tag  out  TAG_W  tag granted; equals tail pointer
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  producing entry
- cdb_value  in  XLEN  result
- cdb_mispredict  in  1  control-flow result disagrees with prediction
- cdb_target  in  XLEN  correct next PC when mispredicted
- op1_tag, op2_tag  in  TAG_W  tags looked up by dispatch
- op1_ready, op2_ready  out  1  value for that tag available
- op1_value, op2_value  out  XLEN  the value
- commit_valid  out  1  head retires this cycle
- commit_rd  out  5  register file write address
- commit_value  out  XLEN  register file write data
- commit_tag  out  TAG_W  tag being retired
- flush  out  1  squash all speculative state; drives the rename table flush input
- flush_pc  out  XLEN  fetch redirect target
- count  out  TAG_W+1  occupied entries

Behaviour:
- Per-entry state: busy, done, rd, value, pc, mispredict, target.
- Global state: head, tail (TAG_W bits each, wrap modulo DEPTH) and count.
- Reset: all busy/done/mispredict bits = 0; head = tail = count = 0.
- Output values out of reset: alloc_ready = 1, alloc_tag = 0, commit_valid = 0, flush = 0, op*_ready = 0, count = 0. Data outputs are don't-care while their valid is low.
- Allocation:
  - alloc_ready = (count < DEPTH) and not flush.
  - alloc_tag = tail, presented combinationally.
  - On alloc_valid && alloc_ready: entry[tail] gets busy=1, done=0, mispredict=0, rd, pc; tail increments on the next edge.
  - When full, allocation is blocked even if a commit occurs in the same cycle. No same-cycle slot reuse.
- CDB capture:
  - On cdb_valid with entry[cdb_tag].busy: set done=1, value, mispredict, target at the next edge.
  - A broadcast to a non-busy entry is ignored.
- Operand lookup is combinational, with CDB bypass. For each op port:
  - ready = entry.busy && (entry.done || (cdb_valid && cdb_tag == tag)).
  - value = cdb_value when the bypass hits, else entry.value.
- Commit:
  - commit_valid = entry[head].busy && entry[head].done, combinational. At most one retire per cycle.
  - On commit, entry[head].busy is cleared and head increments at the next edge.
  - commit_rd is forced to 0 when the entry's rd is 0. The register file ignores rd 0.
- Flush:
  - When the committing head has mispredict=1: commit_valid=1 (the link value still retires), flush=1, flush_pc = target, all combinational in that cycle.
  - Next edge: every busy bit cleared; head = tail = count = 0.
  - Any allocation attempted in the flush cycle is refused (alloc_ready = 0).
  - Any CDB write in the flush cycle is discarded.
- count update: count_next = count + alloc_fire − commit_fire. Simultaneous alloc and commit leaves count unchanged.
- Reset takes priority over every event, including a flush in progress.
- CDB broadcasts arriving during reset are lost. Functional units are reset in the same cycle.

Decomposition:
- Shared package (e.g. tomasulo_pkg) holds:
  - constants ROB_DEPTH and ROB_TAG_W;
  - typedef rob_tag_t;
  - packed struct rob_entry_t {busy, done, mispredict, rd, value, pc, target}.
- One sub-module, rob_ptr: a wrapping pointer plus count tracker (inc/dec, full/empty). It is reusable by the reservation-station free lists.
- Entry storage stays in reorder_buffer.

Test Plan:
- Reset, then allocate 3 entries (rd=5,6,7) → alloc_tag 0,1,2; count=3; commit_valid=0.
- CDB tag1 value 0xAA, then tag0 value 0x11 → commit tag0 (rd5, 0x11), then the next cycle tag1 (rd6, 0xAA). Tag2 stays pending; in-order retire holds.
- Fill all 32 entries → alloc_ready=0 at count=32. Complete tag0 → commit occurs, alloc_ready=1 the next cycle; the new alloc_tag=0 (wrap).
- Operand bypass: op1_tag=3 while cdb_valid with tag3, 0x1234 → op1_ready=1, op1_value=0x1234 the same cycle.
- Mispredict: tag0 completes with cdb_mispredict=1, target 0x400, and 4 younger entries are busy → commit_valid=1, flush=1, flush_pc=0x400 in one cycle. The next cycle count=0, alloc_tag=0; a late CDB write to tag2 is ignored.
- Reset asserted with 10 entries busy and a CDB broadcast present → the next cycle count=0, commit_valid=0, flush=0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the Tomasulo reorder buffer and its pointer logic.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 32;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
  localparam int ROB_XLEN  = 32;
  localparam int REG_W     = 5;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic                busy;
    logic                done;
    logic                mispredict;
    logic [REG_W-1:0]    rd;
    logic [ROB_XLEN-1:0] value;
    logic [ROB_XLEN-1:0] pc;
    logic [ROB_XLEN-1:0] target;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping read/write pointer pair with an occupancy count; shared by the ROB
// and the reservation-station free lists.
module rob_ptr #(
  parameter int DEPTH = 32,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W:0]   count_q, count_d;

  // Callers guarantee push only when not full and pop only when not empty;
  // pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_d    = wr_q + PTR_W'(push);
    rd_d    = rd_q + PTR_W'(pop);
    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    if (clear) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign wr_ptr = wr_q;
  assign rd_ptr = rd_q;
  assign count  = count_q;
  assign full   = (count_q == (PTR_W+1)'(DEPTH));
  assign empty  = (count_q == '0);

endmodule

// File: rtl/reorder_buffer.sv
// 32-entry circular reorder buffer: tag allocation, CDB capture with operand
// bypass, in-order retirement and mispredict flush from the head.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = ROB_TAG_W,
  parameter int XLEN  = ROB_XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  input  logic [XLEN-1:0]  alloc_pc,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_value,
  input  logic             cdb_mispredict,
  input  logic [XLEN-1:0]  cdb_target,
  input  logic [TAG_W-1:0] op1_tag,
  input  logic [TAG_W-1:0] op2_tag,
  output logic             op1_ready,
  output logic             op2_ready,
  output logic [XLEN-1:0]  op1_value,
  output logic [XLEN-1:0]  op2_value,
  output logic             commit_valid,
  output logic [4:0]       commit_rd,
  output logic [XLEN-1:0]  commit_value,
  output logic [TAG_W-1:0] commit_tag,
  output logic             flush,
  output logic [XLEN-1:0]  flush_pc,
  output logic [TAG_W:0]   count
);

  rob_entry_t entries_q [DEPTH];
  rob_entry_t entries_d [DEPTH];

  logic [TAG_W-1:0] head, tail;
  logic             full, empty;
  logic             alloc_fire;
  logic             cdb_fire;
  logic             op1_bypass, op2_bypass;

  rob_ptr #(.DEPTH(DEPTH), .PTR_W(TAG_W)) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush),
    .push   (alloc_fire),
    .pop    (commit_valid),
    .wr_ptr (tail),
    .rd_ptr (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Full blocks allocation even when the head retires this cycle: the freed
  // slot only becomes visible after the edge.
  assign alloc_ready = !full && !flush;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail;

  assign commit_valid = !empty && entries_q[head].busy && entries_q[head].done;
  assign commit_rd    = entries_q[head].rd;
  assign commit_value = entries_q[head].value;
  assign commit_tag   = head;
  assign flush        = commit_valid && entries_q[head].mispredict;
  assign flush_pc     = entries_q[head].target;

  assign cdb_fire = cdb_valid && entries_q[cdb_tag].busy && !flush;

  assign op1_bypass = cdb_valid && (cdb_tag == op1_tag);
  assign op2_bypass = cdb_valid && (cdb_tag == op2_tag);
  assign op1_ready  = entries_q[op1_tag].busy && (entries_q[op1_tag].done || op1_bypass);
  assign op2_ready  = entries_q[op2_tag].busy && (entries_q[op2_tag].done || op2_bypass);
  assign op1_value  = op1_bypass ? cdb_value : entries_q[op1_tag].value;
  assign op2_value  = op2_bypass ? cdb_value : entries_q[op2_tag].value;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entries_d[i] = entries_q[i];

    if (cdb_fire) begin
      entries_d[cdb_tag].done       = 1'b1;
      entries_d[cdb_tag].value      = cdb_value;
      entries_d[cdb_tag].mispredict = cdb_mispredict;
      entries_d[cdb_tag].target     = cdb_target;
    end

    if (commit_valid) entries_d[head].busy = 1'b0;

    if (alloc_fire) begin
      entries_d[tail].busy       = 1'b1;
      entries_d[tail].done       = 1'b0;
      entries_d[tail].mispredict = 1'b0;
      entries_d[tail].rd         = alloc_rd;
      entries_d[tail].pc         = alloc_pc;
    end

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries_d[i].busy = 1'b0;
    end
  end

  // NOTE: only the control bits are reset; payload fields are qualified by
  // busy/done, so leaving them unreset keeps the storage a plain RAM-like array.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i].busy       <= 1'b0;
        entries_q[i].done       <= 1'b0;
        entries_q[i].mispredict <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
    end
  end

endmodule
